// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
//   Shares one 4-lane (32-bit) S-box lookup port between the round datapath
//   (SubBytes on a 128-bit state, 4 beats) and key expansion (SubWord on a
//   32-bit word, 1 beat). Beats are issued on sb_rd/sb_addr, tracked through a
//   tag pipe whose depth matches the S-box read latency, reassembled, and then
//   returned with a one-cycle done pulse.
//
//   Handshake: a requester raises *_req (level) and holds it. It is sampled
//   only while the FSM is IDLE and sbox_ready=1. The input word is latched on
//   the grant edge. *_done pulses for exactly one cycle with *_out valid, and
//   the requester must drop *_req in that cycle. A req still high at the
//   following edge counts as a new request.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   sbox_ready        S-box table loaded; a drop mid-transaction aborts it
//   st_req/st_in      SubBytes request / state ([127:96] = beat 0)
//   st_done/st_out    SubBytes done pulse / substituted state
//   kw_req/kw_in      SubWord request / key word
//   kw_done/kw_out    SubWord done pulse / substituted key word
//   sb_rd/sb_addr     lookup issue strobe / 4 byte addresses
//   sb_data           4 substituted bytes, SBOX_LAT edges after issue
//   busy              FSM not in IDLE
//   abort             one-cycle pulse: transaction killed by sbox_ready drop
module sbox_share_arbiter #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sbox_ready,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         kw_req,
  input  logic [31:0]  kw_in,
  output logic         kw_done,
  output logic [31:0]  kw_out,
  output logic         sb_rd,
  output logic [31:0]  sb_addr,
  input  logic [31:0]  sb_data,
  output logic         busy,
  output logic         abort
);

  typedef enum logic [1:0] {IDLE, ST_ISSUE, KW_ISSUE, DRAIN} state_t;

  localparam logic OWN_ST = 1'b0;
  localparam logic OWN_KW = 1'b1;

  state_t         state, state_n;
  logic           last_grant, last_grant_n;
  logic [127:0]   st_lat, st_lat_n;
  logic [31:0]    kw_lat, kw_lat_n;
  logic           iss_owner, iss_owner_n;
  logic [1:0]     iss_beat, iss_beat_n;
  logic           sb_rd_n;
  logic [31:0]    sb_addr_n;
  logic [127:0]   st_asm, st_asm_n;
  logic [127:0]   st_out_n;
  logic [31:0]    kw_out_n;
  logic           st_done_n, kw_done_n, abort_n;

  // Tag pipe: stage i holds the beat issued i+1 edges ago.
  logic [SBOX_LAT-1:0]      tag_v;
  logic [SBOX_LAT-1:0]      tag_own;
  logic [SBOX_LAT-1:0][1:0] tag_beat;

  logic       flush;
  logic       cap, cap_last, cap_own;
  logic [1:0] cap_beat;
  logic       grant_kw;

  function automatic logic [31:0] beat_word(input logic [127:0] s, input logic [1:0] k);
    logic [31:0] w;
    w = s[127:96];
    case (k)
      2'd0: w = s[127:96];
      2'd1: w = s[95:64];
      2'd2: w = s[63:32];
      2'd3: w = s[31:0];
      default: w = s[127:96];
    endcase
    return w;
  endfunction

  // A sbox_ready drop outside IDLE kills the transaction; at that edge no
  // capture is allowed so nothing partial can leak.
  assign flush    = (state != IDLE) && !sbox_ready;
  assign cap      = tag_v[SBOX_LAT-1] && !flush;
  assign cap_own  = tag_own[SBOX_LAT-1];
  assign cap_beat = tag_beat[SBOX_LAT-1];
  assign cap_last = cap && ((cap_own == OWN_KW) || (cap_beat == 2'd3));
  // Round-robin: KW wins a tie when ST was the last one granted.
  assign grant_kw = kw_req && (!st_req || (last_grant == OWN_ST));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    st_lat_n     = st_lat;
    kw_lat_n     = kw_lat;
    iss_owner_n  = iss_owner;
    iss_beat_n   = iss_beat;
    sb_rd_n      = 1'b0;
    sb_addr_n    = sb_addr;
    st_asm_n     = st_asm;
    st_out_n     = st_out;
    kw_out_n     = kw_out;
    st_done_n    = 1'b0;
    kw_done_n    = 1'b0;
    abort_n      = 1'b0;

    if (flush) begin
      state_n = IDLE;
      abort_n = 1'b1;
    end else begin
      if (cap) begin
        if (cap_own == OWN_KW) begin
          kw_out_n  = sb_data;
          kw_done_n = 1'b1;
        end else begin
          case (cap_beat)
            2'd0: st_asm_n[127:96] = sb_data;
            2'd1: st_asm_n[95:64]  = sb_data;
            2'd2: st_asm_n[63:32]  = sb_data;
            2'd3: st_asm_n[31:0]   = sb_data;
            default: st_asm_n = st_asm;
          endcase
          // st_out only changes once the whole state is assembled.
          if (cap_last) begin
            st_out_n  = st_asm_n;
            st_done_n = 1'b1;
          end
        end
      end

      case (state)
        IDLE: begin
          if (sbox_ready && (st_req || kw_req)) begin
            sb_rd_n    = 1'b1;
            iss_beat_n = 2'd0;
            if (grant_kw) begin
              state_n      = KW_ISSUE;
              kw_lat_n     = kw_in;
              sb_addr_n    = kw_in;
              iss_owner_n  = OWN_KW;
              last_grant_n = OWN_KW;
            end else begin
              state_n      = ST_ISSUE;
              st_lat_n     = st_in;
              sb_addr_n    = st_in[127:96];
              iss_owner_n  = OWN_ST;
              last_grant_n = OWN_ST;
            end
          end
        end
        ST_ISSUE: begin
          if (iss_beat == 2'd3) begin
            state_n = DRAIN;
          end else begin
            sb_rd_n    = 1'b1;
            iss_beat_n = iss_beat + 2'd1;
            sb_addr_n  = beat_word(st_lat, iss_beat + 2'd1);
          end
        end
        KW_ISSUE: begin
          state_n = DRAIN;
        end
        DRAIN: begin
          if (cap_last) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= OWN_ST;
      st_lat     <= '0;
      kw_lat     <= '0;
      iss_owner  <= 1'b0;
      iss_beat   <= 2'd0;
      sb_rd      <= 1'b0;
      sb_addr    <= '0;
      st_asm     <= '0;
      st_out     <= '0;
      kw_out     <= '0;
      st_done    <= 1'b0;
      kw_done    <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      st_lat     <= st_lat_n;
      kw_lat     <= kw_lat_n;
      iss_owner  <= iss_owner_n;
      iss_beat   <= iss_beat_n;
      sb_rd      <= sb_rd_n;
      sb_addr    <= sb_addr_n;
      st_asm     <= st_asm_n;
      st_out     <= st_out_n;
      kw_out     <= kw_out_n;
      st_done    <= st_done_n;
      kw_done    <= kw_done_n;
      abort      <= abort_n;
    end
  end

  // The issue registers act as the stage ahead of tag[0], so a beat reaches
  // the tail exactly when its sb_data is valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v    <= '0;
      tag_own  <= '0;
      tag_beat <= '0;
    end else if (flush) begin
      tag_v    <= '0;
      tag_own  <= '0;
      tag_beat <= '0;
    end else begin
      tag_v[0]    <= sb_rd;
      tag_own[0]  <= iss_owner;
      tag_beat[0] <= iss_beat;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_own[i]  <= tag_own[i-1];
        tag_beat[i] <= tag_beat[i-1];
      end
    end
  end

endmodule

// File: tb/tb_sbox_share_arbiter.sv
module tb_sbox_share_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT a: SBOX_LAT=1 ----------------
  logic         a_sbox_ready, a_st_req, a_st_done, a_kw_req, a_kw_done;
  logic         a_sb_rd, a_busy, a_abort;
  logic [127:0] a_st_in, a_st_out;
  logic [31:0]  a_kw_in, a_kw_out, a_sb_addr, a_sb_data;

  sbox_share_arbiter #(.SBOX_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .sbox_ready(a_sbox_ready),
    .st_req(a_st_req), .st_in(a_st_in), .st_done(a_st_done), .st_out(a_st_out),
    .kw_req(a_kw_req), .kw_in(a_kw_in), .kw_done(a_kw_done), .kw_out(a_kw_out),
    .sb_rd(a_sb_rd), .sb_addr(a_sb_addr), .sb_data(a_sb_data),
    .busy(a_busy), .abort(a_abort)
  );

  // ---------------- DUT b: SBOX_LAT=2 ----------------
  logic         b_sbox_ready, b_st_req, b_st_done, b_kw_req, b_kw_done;
  logic         b_sb_rd, b_busy, b_abort;
  logic [127:0] b_st_in, b_st_out;
  logic [31:0]  b_kw_in, b_kw_out, b_sb_addr, b_sb_data;

  sbox_share_arbiter #(.SBOX_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .sbox_ready(b_sbox_ready),
    .st_req(b_st_req), .st_in(b_st_in), .st_done(b_st_done), .st_out(b_st_out),
    .kw_req(b_kw_req), .kw_in(b_kw_in), .kw_done(b_kw_done), .kw_out(b_kw_out),
    .sb_rd(b_sb_rd), .sb_addr(b_sb_addr), .sb_data(b_sb_data),
    .busy(b_busy), .abort(b_abort)
  );

  // ---------------- S-box RAM models ----------------
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [2047:0] t;
    int i;
    t = SBOX_TAB;
    i = int'(x);
    return t[2047 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] lookup32(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction

  logic [31:0] a_d1, b_d1, b_d2;
  always @(posedge clk) begin
    a_d1 <= lookup32(a_sb_addr);
    b_d1 <= lookup32(b_sb_addr);
    b_d2 <= b_d1;
  end
  assign a_sb_data = a_d1;
  assign b_sb_data = b_d2;

  // ---------------- scoreboard ----------------
  // entry = {owner (1=KW), expected done cycle, data}
  localparam int W = 161;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push_a(input logic own, input int c, input logic [127:0] d);
    exp_a_q.push_back({own, c[31:0], d});
  endtask

  task automatic push_b(input logic own, input int c, input logic [127:0] d);
    exp_b_q.push_back({own, c[31:0], d});
  endtask

  task automatic cmp_entry(input string nm, input logic [W-1:0] e, input logic own,
                           input logic [127:0] act);
    check({nm, "_owner"}, 128'(own), 128'(e[160]));
    check({nm, "_cycle"}, 128'(cyc), 128'(e[159:128]));
    check({nm, "_data"}, act, e[127:0]);
  endtask

  task automatic unexpected(input string nm, input logic [127:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: done with %h, required no done", nm, act);
  endtask

  // monitor: pops and compares whenever a done pulse is presented
  always @(negedge clk) begin
    if (a_st_done) begin
      if (exp_a_q.size() > 0) cmp_entry("a_st", exp_a_q.pop_front(), 1'b0, a_st_out);
      else unexpected("a_st_unexpected", a_st_out);
    end
    if (a_kw_done) begin
      if (exp_a_q.size() > 0) cmp_entry("a_kw", exp_a_q.pop_front(), 1'b1, 128'(a_kw_out));
      else unexpected("a_kw_unexpected", 128'(a_kw_out));
    end
    if (b_st_done) begin
      if (exp_b_q.size() > 0) cmp_entry("b_st", exp_b_q.pop_front(), 1'b0, b_st_out);
      else unexpected("b_st_unexpected", b_st_out);
    end
    if (b_kw_done) begin
      if (exp_b_q.size() > 0) cmp_entry("b_kw", exp_b_q.pop_front(), 1'b1, 128'(b_kw_out));
      else unexpected("b_kw_unexpected", 128'(b_kw_out));
    end
  end

  // ---------------- driver tasks ----------------
  // Requester behaviour: drop req in the done cycle; bounded wait.
  task automatic wait_idle_a(input int budget);
    int n = 0;
    while ((a_st_req || a_kw_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (a_st_done) a_st_req = 1'b0;
      if (a_kw_done) a_kw_req = 1'b0;
    end
    check("a_done_timeout", 128'({a_st_req, a_kw_req}), 128'(0));
    a_st_req = 1'b0;
    a_kw_req = 1'b0;
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    while ((b_st_req || b_kw_req) && n < budget) begin
      @(negedge clk);
      n++;
      if (b_st_done) b_st_req = 1'b0;
      if (b_kw_done) b_kw_req = 1'b0;
    end
    check("b_done_timeout", 128'({b_st_req, b_kw_req}), 128'(0));
    b_st_req = 1'b0;
    b_kw_req = 1'b0;
  endtask

  task automatic check_a_zero(input string nm);
    check({nm, "_st_out"}, a_st_out, 128'(0));
    check({nm, "_kw_out"}, 128'(a_kw_out), 128'(0));
    check({nm, "_ctl"}, 128'({a_st_done, a_kw_done, a_sb_rd, a_busy, a_abort}), 128'(0));
    check({nm, "_sb_addr"}, 128'(a_sb_addr), 128'(0));
  endtask

  localparam logic [127:0] V3_ST  = {32'h00112233, 32'h53ff0001, 32'h10203040, 32'h00010203};
  localparam logic [127:0] V3_EXP = {32'h638293c3, 32'hed16637c, 32'hcab70409, 32'h637c777b};

  // ---------------- stimulus ----------------
  initial begin
    int c;
    logic [127:0] prev_st;
    a_sbox_ready = 1'b0; a_st_req = 1'b0; a_kw_req = 1'b0; a_st_in = '0; a_kw_in = '0;
    b_sbox_ready = 1'b0; b_st_req = 1'b0; b_kw_req = 1'b0; b_st_in = '0; b_kw_in = '0;
    repeat (3) @(negedge clk);
    check_a_zero("reset_a");
    check("reset_b_ctl", 128'({b_st_done, b_kw_done, b_sb_rd, b_busy, b_abort}), 128'(0));
    reset = 1'b0;
    a_sbox_ready = 1'b1;
    b_sbox_ready = 1'b1;
    @(negedge clk);

    // 1: ST only, LAT=1
    a_st_in = {4{32'h000153ff}};
    a_st_req = 1'b1;
    c = cyc;
    push_a(1'b0, c + 6, {4{32'h637ced16}});
    @(negedge clk);
    a_st_in = '1;  // requester may change data after the grant
    check("t1_issue", 128'({a_busy, a_sb_rd, a_sb_addr}), 128'({2'b11, 32'h000153ff}));
    wait_idle_a(40);
    @(negedge clk);

    // 2: KW only, LAT=2; then ST on LAT=2 to exercise beat ordering
    b_kw_in = 32'h00010203;
    b_kw_req = 1'b1;
    c = cyc;
    push_b(1'b1, c + 4, 128'(32'h637c777b));
    @(negedge clk);
    b_kw_in = 32'hffffffff;
    wait_idle_b(40);
    @(negedge clk);
    b_st_in = V3_ST;
    b_st_req = 1'b1;
    c = cyc;
    push_b(1'b0, c + 7, V3_EXP);
    @(negedge clk);
    b_st_in = '0;
    wait_idle_b(40);
    @(negedge clk);

    // 3: simultaneous requests; last grant was ST, so KW first
    a_st_in = V3_ST;
    a_kw_in = 32'h10203040;
    a_st_req = 1'b1;
    a_kw_req = 1'b1;
    c = cyc;
    push_a(1'b1, c + 3, 128'(32'hcab70409));
    push_a(1'b0, c + 9, V3_EXP);
    wait_idle_a(60);
    @(negedge clk);
    a_st_in = {4{32'h00010203}};
    a_kw_in = 32'h53ff0001;
    a_st_req = 1'b1;
    a_kw_req = 1'b1;
    c = cyc;
    push_a(1'b1, c + 3, 128'(32'hed16637c));
    push_a(1'b0, c + 9, {4{32'h637c777b}});
    wait_idle_a(60);
    @(negedge clk);
    // a lone KW, then a tie: ST must now win
    a_kw_in = 32'h00112233;
    a_kw_req = 1'b1;
    c = cyc;
    push_a(1'b1, c + 3, 128'(32'h638293c3));
    wait_idle_a(40);
    @(negedge clk);
    a_st_in = {4{32'h53ff0001}};
    a_kw_in = 32'h00010203;
    a_st_req = 1'b1;
    a_kw_req = 1'b1;
    c = cyc;
    push_a(1'b0, c + 6, {4{32'hed16637c}});
    push_a(1'b1, c + 9, 128'(32'h637c777b));
    wait_idle_a(60);
    @(negedge clk);

    // 4: kw_req rises during ST beat 1, no preemption
    a_st_in = {32'h10203040, 32'h00112233, 32'h00010203, 32'h53ff0001};
    a_st_req = 1'b1;
    c = cyc;
    push_a(1'b0, c + 6, {32'hcab70409, 32'h638293c3, 32'h637c777b, 32'hed16637c});
    repeat (2) @(negedge clk);
    a_kw_in = 32'hff535300;
    a_kw_req = 1'b1;
    push_a(1'b1, c + 9, 128'(32'h16eded63));
    wait_idle_a(60);
    prev_st = {32'hcab70409, 32'h638293c3, 32'h637c777b, 32'hed16637c};
    @(negedge clk);

    // 5: sbox_ready dropped in ST beat 2 -> abort, no done, then rerun
    a_st_in = V3_ST;
    a_st_req = 1'b1;
    repeat (3) @(negedge clk);
    a_sbox_ready = 1'b0;
    @(negedge clk);
    check("t5_abort", 128'({a_abort, a_busy, a_sb_rd}), 128'(3'b100));
    check("t5_st_out_kept", a_st_out, prev_st);
    repeat (3) @(negedge clk);
    check("t5_wait", 128'({a_abort, a_busy, a_sb_rd, a_st_done}), 128'(0));
    a_sbox_ready = 1'b1;
    c = cyc;
    push_a(1'b0, c + 6, V3_EXP);
    wait_idle_a(40);
    @(negedge clk);

    // 6: reset pulse mid-DRAIN, then a fresh KW
    a_st_in = {4{32'h00112233}};
    a_st_req = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_in_drain", 128'({a_busy, a_sb_rd}), 128'(2'b10));
    reset = 1'b1;
    a_st_req = 1'b0;
    #1;
    check_a_zero("t6_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_no_abort", 128'({a_abort, a_st_done, a_busy}), 128'(0));
    a_kw_in = 32'h53ff0001;
    a_kw_req = 1'b1;
    c = cyc;
    push_a(1'b1, c + 3, 128'(32'hed16637c));
    wait_idle_a(40);
    repeat (3) @(negedge clk);

    check("a_queue_empty", 128'(exp_a_q.size()), 128'(0));
    check("b_queue_empty", 128'(exp_b_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time expired, required finish");
    $fatal(1);
  end

endmodule
